icmp_echo_responder: RTL

- Consumes IPv4 frames from the IP stack's IP output (hdr plus 8-bit payload stream).
- Answers ICMP echo requests (type 8, code 0) addressed to local_ip by streaming an echo reply back into the IP stack's IP input.
- Payload is cut through with no frame buffer. The ICMP checksum is updated incrementally per RFC 1624.
- All other frames are consumed and dropped.

---
 rtl/icmp_echo_responder_pkg.sv | 27 ++
 rtl/icmp_echo_responder_csum.sv | 16 +
 rtl/icmp_echo_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/icmp_echo_responder_pkg.sv
// Shared constants, FSM encoding and one's-complement helper for the ICMP echo responder.
package icmp_echo_responder_pkg;

   localparam logic [7:0]  IP_PROTO_ICMP     = 8'd1;
   localparam logic [7:0]  ICMP_ECHO_REQUEST = 8'd8;
   localparam logic [7:0]  ICMP_ECHO_REPLY   = 8'd0;
   localparam logic [7:0]  ICMP_CODE_ZERO    = 8'd0;
   localparam logic [15:0] MIN_ICMP_IP_LEN   = 16'd24;
   localparam logic [31:0] IP_BROADCAST      = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_HDR   = 3'd2,
      ST_ICMPH = 3'd3,
      ST_PASS  = 3'd4,
      ST_DROP  = 3'd5
   } state_e;

   // End-around carry: two folds cover any sum of three 16-bit terms.
   function automatic logic [15:0] csum_fold(input logic [17:0] sum);
      logic [16:0] s1;
      s1 = {1'b0, sum[15:0]} + {15'd0, sum[17:16]};
      return s1[15:0] + {15'd0, s1[16]};
   endfunction

endpackage

// File: rtl/icmp_echo_responder_csum.sv
// Incremental 16-bit Internet checksum update: HC' = ~(~HC + ~m + m').
module ones_comp_csum_update
   import icmp_echo_responder_pkg::*;
(
   input  logic [15:0] old_csum_i,
   input  logic [15:0] old_word_i,
   input  logic [15:0] new_word_i,
   output logic [15:0] new_csum_o
);

   logic [17:0] sum_s;

   assign sum_s      = {2'b00, ~old_csum_i} + {2'b00, ~old_word_i} + {2'b00, new_word_i};
   assign new_csum_o = ~csum_fold(sum_s);

endmodule

// File: rtl/icmp_echo_responder.sv
// Answers ICMP echo requests addressed to local_ip; payload is cut through after a rewritten
// 4-byte ICMP header, everything else is consumed and dropped.
module icmp_echo_responder
   import icmp_echo_responder_pkg::*;
#(
   parameter int REPLY_TTL       = 64,
   parameter bit ALLOW_BROADCAST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_ip_hdr_valid,
   output logic        s_ip_hdr_ready,
   input  logic [5:0]  s_ip_dscp,
   input  logic [1:0]  s_ip_ecn,
   input  logic [15:0] s_ip_length,
   input  logic [2:0]  s_ip_flags,
   input  logic [12:0] s_ip_fragment_offset,
   input  logic [7:0]  s_ip_protocol,
   input  logic [31:0] s_ip_source_ip,
   input  logic [31:0] s_ip_dest_ip,
   input  logic [7:0]  s_ip_payload_axis_tdata,
   input  logic        s_ip_payload_axis_tvalid,
   output logic        s_ip_payload_axis_tready,
   input  logic        s_ip_payload_axis_tlast,
   input  logic        s_ip_payload_axis_tuser,
   output logic        m_ip_hdr_valid,
   input  logic        m_ip_hdr_ready,
   output logic [5:0]  m_ip_dscp,
   output logic [1:0]  m_ip_ecn,
   output logic [15:0] m_ip_length,
   output logic [7:0]  m_ip_ttl,
   output logic [7:0]  m_ip_protocol,
   output logic [31:0] m_ip_source_ip,
   output logic [31:0] m_ip_dest_ip,
   output logic [7:0]  m_ip_payload_axis_tdata,
   output logic        m_ip_payload_axis_tvalid,
   input  logic        m_ip_payload_axis_tready,
   output logic        m_ip_payload_axis_tlast,
   output logic        m_ip_payload_axis_tuser,
   input  logic [31:0] local_ip,
   output logic        busy,
   output logic        stat_reply,
   output logic        stat_drop,
   output logic        stat_short
);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  type_q, type_d, code_q, code_d, csum_hi_q, csum_hi_d;
   logic [15:0] csum_new_q, csum_new_d, csum_upd_s;
   logic        zero_data_q, zero_data_d;
   logic [5:0]  dscp_q, dscp_d;
   logic [1:0]  ecn_q, ecn_d;
   logic [15:0] len_q, len_d;
   logic [31:0] src_q, src_d;
   logic        reply_q, reply_d, drop_q, drop_d, short_q, short_d;
   logic        hdr_ok_s;
   logic        unused_flags_s;

   assign unused_flags_s = ^s_ip_flags[2:1];

   assign hdr_ok_s = (s_ip_protocol == IP_PROTO_ICMP) && !s_ip_flags[0] &&
                     (s_ip_fragment_offset == 13'd0) && (s_ip_length >= MIN_ICMP_IP_LEN) &&
                     ((s_ip_dest_ip == local_ip) || (ALLOW_BROADCAST && (s_ip_dest_ip == IP_BROADCAST)));

   // Only the type/code word changes (0x0800 -> 0x0000), so the update is a constant delta.
   ones_comp_csum_update u_csum (
      .old_csum_i (({csum_hi_q, s_ip_payload_axis_tdata})),
      .old_word_i ({ICMP_ECHO_REQUEST, ICMP_CODE_ZERO}),
      .new_word_i ({ICMP_ECHO_REPLY, ICMP_CODE_ZERO}),
      .new_csum_o (csum_upd_s)
   );

   assign m_ip_dscp      = dscp_q;
   assign m_ip_ecn       = ecn_q;
   assign m_ip_length    = len_q;
   assign m_ip_ttl       = 8'(REPLY_TTL);
   assign m_ip_protocol  = IP_PROTO_ICMP;
   assign m_ip_source_ip = local_ip;
   assign m_ip_dest_ip   = src_q;
   assign busy           = (state_q != ST_IDLE);
   assign stat_reply     = reply_q;
   assign stat_drop      = drop_q;
   assign stat_short     = short_q;

   always_comb begin
      state_d = state_q;   cnt_d = cnt_q;   type_d = type_q;   code_d = code_q;
      csum_hi_d = csum_hi_q;   csum_new_d = csum_new_q;   zero_data_d = zero_data_q;
      dscp_d = dscp_q;   ecn_d = ecn_q;   len_d = len_q;   src_d = src_q;
      reply_d = 1'b0;   drop_d = 1'b0;   short_d = 1'b0;
      s_ip_hdr_ready = 1'b0;   s_ip_payload_axis_tready = 1'b0;   m_ip_hdr_valid = 1'b0;
      m_ip_payload_axis_tdata = 8'h00;   m_ip_payload_axis_tvalid = 1'b0;
      m_ip_payload_axis_tlast = 1'b0;    m_ip_payload_axis_tuser = 1'b0;
      case (state_q)
         ST_IDLE: begin
            s_ip_hdr_ready = !rst;
            if (s_ip_hdr_valid && !rst) begin
               dscp_d = s_ip_dscp;   ecn_d = s_ip_ecn;   len_d = s_ip_length;   src_d = s_ip_source_ip;
               cnt_d = 2'd0;   zero_data_d = 1'b0;
               state_d = hdr_ok_s ? ST_READ : ST_DROP;
            end
         end
         ST_READ: begin
            s_ip_payload_axis_tready = 1'b1;
            if (s_ip_payload_axis_tvalid) begin
               cnt_d = cnt_q + 2'd1;
               case (cnt_q)
                  2'd0:    type_d = s_ip_payload_axis_tdata;
                  2'd1:    code_d = s_ip_payload_axis_tdata;
                  2'd2:    csum_hi_d = s_ip_payload_axis_tdata;
                  default: csum_new_d = csum_upd_s;
               endcase
               if (cnt_q != 2'd3) begin
                  if (s_ip_payload_axis_tlast) begin
                     short_d = 1'b1;   drop_d = 1'b1;   state_d = ST_IDLE;
                  end
               end else if (type_q == ICMP_ECHO_REQUEST && code_q == ICMP_CODE_ZERO) begin
                  zero_data_d = s_ip_payload_axis_tlast;
                  state_d = ST_HDR;
               end else if (s_ip_payload_axis_tlast) begin
                  drop_d = 1'b1;   state_d = ST_IDLE;
               end else begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_HDR: begin
            m_ip_hdr_valid = 1'b1;
            if (m_ip_hdr_ready) begin
               cnt_d = 2'd0;   state_d = ST_ICMPH;
            end
         end
         ST_ICMPH: begin
            m_ip_payload_axis_tvalid = 1'b1;
            case (cnt_q)
               2'd0:    m_ip_payload_axis_tdata = ICMP_ECHO_REPLY;
               2'd1:    m_ip_payload_axis_tdata = ICMP_CODE_ZERO;
               2'd2:    m_ip_payload_axis_tdata = csum_new_q[15:8];
               default: m_ip_payload_axis_tdata = csum_new_q[7:0];
            endcase
            // A request with no data bytes ends the reply on the checksum byte.
            m_ip_payload_axis_tlast = zero_data_q && (cnt_q == 2'd3);
            if (m_ip_payload_axis_tready) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  if (zero_data_q) begin
                     reply_d = 1'b1;   state_d = ST_IDLE;
                  end else begin
                     state_d = ST_PASS;
                  end
               end
            end
         end
         ST_PASS: begin
            m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata;
            m_ip_payload_axis_tvalid = s_ip_payload_axis_tvalid;
            m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast;
            m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser;
            s_ip_payload_axis_tready = m_ip_payload_axis_tready;
            if (s_ip_payload_axis_tvalid && m_ip_payload_axis_tready && s_ip_payload_axis_tlast) begin
               reply_d = 1'b1;   state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            s_ip_payload_axis_tready = 1'b1;
            if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) begin
               drop_d = 1'b1;   state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, captured header fields and statistic pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;   cnt_q <= 2'd0;   type_q <= 8'd0;   code_q <= 8'd0;
         csum_hi_q <= 8'd0;   csum_new_q <= 16'd0;   zero_data_q <= 1'b0;
         dscp_q <= 6'd0;   ecn_q <= 2'd0;   len_q <= 16'd0;   src_q <= 32'd0;
         reply_q <= 1'b0;   drop_q <= 1'b0;   short_q <= 1'b0;
      end else begin
         state_q <= state_d;   cnt_q <= cnt_d;   type_q <= type_d;   code_q <= code_d;
         csum_hi_q <= csum_hi_d;   csum_new_q <= csum_new_d;   zero_data_q <= zero_data_d;
         dscp_q <= dscp_d;   ecn_q <= ecn_d;   len_q <= len_d;   src_q <= src_d;
         reply_q <= reply_d;   drop_q <= drop_d;   short_q <= short_d;
      end
   end

endmodule
